// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous RAM between instruction fetch and the LSU.
// The data port has priority, and a starvation counter forces a fetch through after STARVE_LIMIT data wins.
module mem_port_arbiter #(
    parameter int unsigned          ADDR_W       = 32,
    parameter int unsigned          DATA_W       = 32,
    parameter int unsigned          STARVE_LIMIT = 4,
    parameter logic [DATA_W-1:0]    NOP_WORD     = 32'h00000013
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              inst_req_i,
    input  logic [ADDR_W-1:0] inst_addr_i,
    output logic              inst_gnt_o,
    output logic              inst_rvalid_o,
    output logic [DATA_W-1:0] inst_rdata_o,
    input  logic              data_req_i,
    input  logic              data_we_i,
    input  logic [3:0]        data_sel_i,
    input  logic [ADDR_W-1:0] data_addr_i,
    input  logic [DATA_W-1:0] data_wdata_i,
    output logic              data_gnt_o,
    output logic              data_rvalid_o,
    output logic [DATA_W-1:0] data_rdata_o,
    output logic              mem_ce_o,
    output logic              mem_we_o,
    output logic [3:0]        mem_sel_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    localparam int unsigned     SW    = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0]   LIMIT = SW'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        RESP_NONE = 2'd0,
        RESP_INST = 2'd1,
        RESP_DATA = 2'd2
    } resp_e;

    logic [SW-1:0] streak_q;
    resp_e         resp_q;
    logic          force_inst;

    // Gating with rst_ni keeps grants and strobes low for the whole reset window.
    assign force_inst = (streak_q == LIMIT);
    assign inst_gnt_o = rst_ni & inst_req_i & (~data_req_i | force_inst);
    assign data_gnt_o = rst_ni & data_req_i & ~(inst_req_i & force_inst);
    assign mem_ce_o   = inst_gnt_o | data_gnt_o;

    always_comb begin
        mem_we_o    = 1'b0;
        mem_sel_o   = 4'h0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (inst_gnt_o) begin
            mem_sel_o  = 4'hF;
            mem_addr_o = inst_addr_i;
        end else if (data_gnt_o) begin
            mem_we_o    = data_we_i;
            mem_sel_o   = data_sel_i;
            mem_addr_o  = data_addr_i;
            mem_wdata_o = data_wdata_i;
        end
    end

    // resp_q remembers who owns the read data returning on the next cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            streak_q <= '0;
            resp_q   <= RESP_NONE;
        end else begin
            if (inst_gnt_o || !inst_req_i) begin
                streak_q <= '0;
            end else if (data_gnt_o && (streak_q != LIMIT)) begin
                streak_q <= streak_q + 1'b1;
            end

            if (inst_gnt_o) begin
                resp_q <= RESP_INST;
            end else if (data_gnt_o && !data_we_i) begin
                resp_q <= RESP_DATA;
            end else begin
                resp_q <= RESP_NONE;
            end
        end
    end

    assign inst_rvalid_o = (resp_q == RESP_INST);
    assign data_rvalid_o = (resp_q == RESP_DATA);
    assign inst_rdata_o  = inst_rvalid_o ? mem_rdata_i : NOP_WORD;
    assign data_rdata_o  = data_rvalid_o ? mem_rdata_i : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: a behavioural RAM, a reference model
// and per-cycle compare, plus directed scenarios with literal expectations.
module tb_mem_port_arbiter;

    localparam int          LIMIT = 4;
    localparam logic [31:0] NOP   = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        inst_req, data_req, data_we;
    logic [31:0] inst_addr, data_addr, data_wdata, mem_rdata;
    logic [3:0]  data_sel;
    logic        inst_gnt, inst_rvalid, data_gnt, data_rvalid;
    logic [31:0] inst_rdata, data_rdata;
    logic        mem_ce, mem_we;
    logic [3:0]  mem_sel;
    logic [31:0] mem_addr, mem_wdata;

    int checks   = 0;
    int failures = 0;

    mem_port_arbiter #(
        .ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(LIMIT), .NOP_WORD(NOP)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .inst_req_i(inst_req), .inst_addr_i(inst_addr), .inst_gnt_o(inst_gnt),
        .inst_rvalid_o(inst_rvalid), .inst_rdata_o(inst_rdata),
        .data_req_i(data_req), .data_we_i(data_we), .data_sel_i(data_sel),
        .data_addr_i(data_addr), .data_wdata_i(data_wdata), .data_gnt_o(data_gnt),
        .data_rvalid_o(data_rvalid), .data_rdata_o(data_rdata),
        .mem_ce_o(mem_ce), .mem_we_o(mem_we), .mem_sel_o(mem_sel),
        .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
    );

    always #5 clk = ~clk;

    // Behavioural single-port RAM; returns noise when no read was strobed.
    logic [31:0] ram [0:63] = '{default: 32'h0};
    always @(posedge clk) begin
        if (mem_ce && !mem_we) mem_rdata <= ram[mem_addr[7:2]];
        else                   mem_rdata <= $urandom;
        if (mem_ce && mem_we) begin
            for (int b = 0; b < 4; b++)
                if (mem_sel[b]) ram[mem_addr[7:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: memory image, data wins since fetch began waiting, and response scoreboard.
    logic [31:0] ref_mem [0:63] = '{default: 32'h0};
    int          data_wins = 0;
    logic [31:0] exp_q[$];
    logic [1:0]  own_q[$];
    logic        last_i_g = 1'b0, last_d_g = 1'b0;

    always @(negedge clk) begin
        logic        e_ig, e_dg, e_iv, e_dv, e_we;
        logic [3:0]  e_sel;
        logic [31:0] e_addr, e_wd, e_ird, e_drd, e_dat;
        logic [1:0]  own;
        own = 2'd0;
        e_dat = 32'h0;
        if (exp_q.size() > 0) begin
            e_dat = exp_q.pop_front();
            own   = own_q.pop_front();
        end
        e_ig = 1'b0; e_dg = 1'b0; e_we = 1'b0; e_sel = 4'h0; e_addr = 32'h0; e_wd = 32'h0;
        if (!rst_n) begin
            own = 2'd0;
            data_wins = 0;
        end else begin
            e_ig = inst_req && (!data_req || data_wins >= LIMIT);
            e_dg = data_req && !e_ig;
            if (e_ig) begin
                e_sel = 4'hF; e_addr = inst_addr;
            end else if (e_dg) begin
                e_we = data_we; e_sel = data_sel; e_addr = data_addr; e_wd = data_wdata;
            end
        end
        e_iv  = (own == 2'd1);
        e_dv  = (own == 2'd2);
        e_ird = e_iv ? e_dat : NOP;
        e_drd = e_dv ? e_dat : 32'h0;

        chk("grant", {30'h0, inst_gnt, data_gnt}, {30'h0, e_ig, e_dg});
        chk("mem_ctl", {26'h0, mem_ce, mem_we, mem_sel}, {26'h0, e_ig | e_dg, e_we, e_sel});
        chk("mem_addr", mem_addr, e_addr);
        chk("mem_wdata", mem_wdata, e_wd);
        chk("rvalid", {30'h0, inst_rvalid, data_rvalid}, {30'h0, e_iv, e_dv});
        chk("inst_rdata", inst_rdata, e_ird);
        chk("data_rdata", data_rdata, e_drd);
        chk("rvalid_excl", {31'h0, inst_rvalid & data_rvalid}, 32'h0);

        if (rst_n) begin
            if (e_ig) begin
                exp_q.push_back(ref_mem[inst_addr[7:2]]); own_q.push_back(2'd1);
            end else if (e_dg && !data_we) begin
                exp_q.push_back(ref_mem[data_addr[7:2]]); own_q.push_back(2'd2);
            end else if (e_dg && data_we) begin
                for (int b = 0; b < 4; b++)
                    if (data_sel[b]) ref_mem[data_addr[7:2]][8*b +: 8] = data_wdata[8*b +: 8];
            end
            if (!inst_req || e_ig) data_wins = 0;
            else if (e_dg)         data_wins++;
        end
        last_i_g = e_ig;
        last_d_g = e_dg;
    end

    task automatic drive(input logic ir, input logic [31:0] ia, input logic dr, input logic we,
                         input logic [3:0] sel, input logic [31:0] da, input logic [31:0] wd);
        @(posedge clk); #1;
        inst_req = ir; inst_addr = ia; data_req = dr; data_we = we;
        data_sel = sel; data_addr = da; data_wdata = wd;
    endtask

    task automatic idle();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    task automatic settle();
        @(negedge clk); #1;
    endtask

    initial begin
        logic [9:0] pat;
        rst_n = 1'b0;
        inst_req = 1'b1; inst_addr = 32'h0; data_req = 1'b1; data_we = 1'b0;
        data_sel = 4'hF; data_addr = 32'h0; data_wdata = 32'h0;

        // Reset with both requests asserted.
        repeat (3) begin
            settle();
            chk("rst_gnt", {30'h0, inst_gnt, data_gnt}, 32'h0);
            chk("rst_nop", inst_rdata, 32'h00000013);
        end
        @(posedge clk); #1; rst_n = 1'b1;
        settle();
        chk("first_data_gnt", {31'h0, data_gnt}, 32'h1);

        drive(1'b1, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        idle();
        drive(1'b0, 32'h0, 1'b1, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF);

        // Single fetch.
        drive(1'b1, 32'h10, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        settle();
        chk("fetch_gnt", {31'h0, inst_gnt}, 32'h1);
        chk("fetch_addr", mem_addr, 32'h10);
        chk("fetch_sel_we", {27'h0, mem_sel, mem_we}, {27'h0, 4'hF, 1'b0});
        idle();
        settle();
        chk("fetch_rvalid", {31'h0, inst_rvalid}, 32'h1);
        chk("fetch_rdata", inst_rdata, 32'hDEADBEEF);

        // Partial write then read back.
        drive(1'b0, 32'h0, 1'b1, 1'b1, 4'h3, 32'h40, 32'h12345678);
        settle();
        chk("wr_gnt_we", {30'h0, data_gnt, mem_we}, 32'h3);
        drive(1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h40, 32'h0);
        settle();
        chk("wr_no_rvalid", {31'h0, data_rvalid}, 32'h0);
        idle();
        settle();
        chk("rd_rvalid", {31'h0, data_rvalid}, 32'h1);
        chk("rd_rdata", data_rdata, 32'h00005678);

        // Starvation pattern.
        pat = 10'h0;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 32'h10, 1'b1, 1'b0, 4'hF, 32'h40, 32'h0);
            settle();
            pat = {pat[8:0], inst_gnt};
        end
        chk("starve_pattern", {22'h0, pat}, {22'h0, 10'b0000100001});
        idle();
        idle();

        // Reset between a read grant and its response.
        drive(1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h40, 32'h0);
        @(posedge clk); #3;
        rst_n = 1'b0; data_req = 1'b0;
        settle();
        chk("rst_mid_rvalid", {31'h0, data_rvalid}, 32'h0);
        @(posedge clk); #1; rst_n = 1'b1;
        settle();
        chk("post_rst_rvalid", {30'h0, inst_rvalid, data_rvalid}, 32'h0);

        // Interleaved single-port requests.
        drive(1'b1, 32'h10, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        drive(1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h40, 32'h0);
        settle();
        chk("ilv_c2", {30'h0, inst_rvalid, data_rvalid}, 32'h2);
        drive(1'b1, 32'h10, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        settle();
        chk("ilv_c3", {30'h0, inst_rvalid, data_rvalid}, 32'h1);
        idle();
        settle();
        chk("ilv_c4", {30'h0, inst_rvalid, data_rvalid}, 32'h2);
        idle();

        // Random traffic; an ungranted requester holds its request stable.
        for (int n = 0; n < 3000; n++) begin
            @(posedge clk); #1;
            rst_n = ($urandom_range(0, 199) != 0);
            if (!(inst_req && !last_i_g)) begin
                inst_req  = ($urandom_range(0, 99) < 60);
                inst_addr = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
            end
            if (!(data_req && !last_d_g)) begin
                data_req   = ($urandom_range(0, 99) < 70);
                data_we    = $urandom_range(0, 1);
                data_sel   = 4'($urandom_range(0, 15));
                data_addr  = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
                data_wdata = $urandom;
            end
        end
        @(posedge clk); #1; rst_n = 1'b1;
        idle();
        idle();
        settle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one single-port synchronous RAM between the instruction-fetch port and the LSU data port of the core. The data port has fixed priority. A starvation counter guarantees instruction fetch forward progress. The block also routes each one-cycle-latency read response back to the requester that issued it. It sits between the core's fetch/LSU interfaces and the testbench/FPGA memory.

Parameters:
ADDR_W, 32, byte address width of both ports and memory
DATA_W, 32, data/instruction word width
STARVE_LIMIT, 4, max consecutive data grants while inst_req_i is pending before instruction fetch is forced through (>=1)
NOP_WORD, 32'h00000013, value on inst_rdata_o when no instruction response is valid

Ports:
clk_i  in  1  clock, all state on rising edge
rst_ni  in  1  reset, asynchronous, active-low
inst_req_i  in  1  fetch request, held until granted
inst_addr_i  in  ADDR_W  fetch byte address, word aligned
inst_gnt_o  out  1  fetch accepted this cycle
inst_rvalid_o  out  1  fetch data valid
inst_rdata_o  out  DATA_W  fetched word
data_req_i  in  1  LSU request, held until granted
data_we_i  in  1  1=write, 0=read
data_sel_i  in  4  byte enables
data_addr_i  in  ADDR_W  LSU byte address
data_wdata_i  in  DATA_W  write data
data_gnt_o  out  1  LSU request accepted this cycle
data_rvalid_o  out  1  LSU read data valid (reads only)
data_rdata_o  out  DATA_W  LSU read data
mem_ce_o  out  1  memory access strobe
mem_we_o  out  1  memory write enable
mem_sel_o  out  4  memory byte enables (4'hF for fetch)
mem_addr_o  out  ADDR_W  memory address
mem_wdata_o  out  DATA_W  memory write data (0 for fetch)
mem_rdata_i  in  DATA_W  memory read data, valid the cycle after a read strobe

Behaviour:
- Grant is combinational from the requests and registered state. At most one grant per cycle. mem_ce_o = inst_gnt_o | data_gnt_o. When neither is granted, the mem_* outputs are all 0.
- Arbitration:
  - Only one port requesting: that port is granted.
  - Both requesting and streak_q < STARVE_LIMIT: the data port is granted.
  - Both requesting and streak_q == STARVE_LIMIT: the instruction port is granted.
- streak_q counter, width clog2(STARVE_LIMIT+1):
  - +1 on a data grant while inst_req_i=1.
  - Cleared on an inst grant, or in any cycle with inst_req_i=0.
  - Saturates; never exceeds STARVE_LIMIT.
- Response owner register resp_q, values NONE / INST / DATA. Next value:
  - INST on an inst grant.
  - DATA on a data read grant (data_we_i=0).
  - NONE otherwise, including data write grants.
- Response outputs:
  - inst_rvalid_o = (resp_q==INST).
  - data_rvalid_o = (resp_q==DATA).
  - Read latency is exactly 1 cycle after the grant. Back-to-back grants give back-to-back responses.
  - inst_rdata_o = mem_rdata_i when inst_rvalid_o, else NOP_WORD.
  - data_rdata_o = mem_rdata_i when data_rvalid_o, else 0.
- Writes complete at the grant edge and produce no rvalid.
- No queueing. A requester not granted keeps its request and address stable. The block does not check this.
- Reset (async, rst_ni=0):
  - streak_q=0, resp_q=NONE.
  - Every output goes to 0 immediately, except inst_rdata_o=NOP_WORD.
  - An access granted in the cycle before reset produces no rvalid after reset is released.
  - Requests presented during reset are not granted.
- Both rvalids are never high in the same cycle.

Test Plan:
- Reset then idle: rst_ni low for 3 cycles with both requests high → all gnt/rvalid 0, inst_rdata_o=0x00000013. After release, first cycle → data_gnt_o=1.
- Single fetch: inst_req_i=1, addr 0x10, memory word 0xDEADBEEF → inst_gnt_o=1 with mem_addr_o=0x10, mem_sel_o=4'hF, mem_we_o=0. Next cycle inst_rvalid_o=1, inst_rdata_o=0xDEADBEEF.
- Data write then read: write 0x12345678 to 0x40 with sel 4'h3 → data_gnt_o=1, mem_we_o=1, no rvalid. Read 0x40 (initially 0) next cycle → data_rvalid_o=1 one cycle later with 0x00005678.
- Starvation (STARVE_LIMIT=4): both requests held continuously → grant pattern D,D,D,D,I,D,D,D,D,I. Each grant's read response appears on the correct port one cycle later.
- Reset mid-read: data read granted, rst_ni asserted before the next edge → data_rvalid_o stays 0 through and after reset. resp_q=NONE on release.
- Interleaved back-to-back: alternating single-port requests I,D,I over 3 cycles → rvalid sequence inst,data,inst on cycles 2-4, never both high.
